// File: rtl/vga_rx.sv
// vga_rx -- pixel-clock VGA receiver for the 640x480@60 output path.
//
// Samples HS/VS and 12-bit RGB, rebuilds the pixel grid from the sync
// edges, checks every line and frame length against the configured mode,
// and declares lock after LOCK_FRAMES consecutive good frames. While
// locked it emits each active pixel with its coordinates.
//
// Optional feature macro: VGA_RX_STATS_EN
//   defined     -> h_total / v_total latch measured lengths at each check,
//                  err_count counts timing_err pulses (saturating at 255)
//   not defined -> those three outputs are tied to 0, no registers built
//
// Ports
//   clk          pixel clock, same source as the generator
//   reset        asynchronous, active-low; clears all state
//   vga_hs/vs    active-low sync inputs
//   vga_r/g/b    4-bit colour inputs
//   pix_valid    active-region pixel present on pix_* (only while locked)
//   pix_x/pix_y  0-based coordinate within the active area
//   pix_rgb      {r,g,b} of that pixel
//   frame_start  one-cycle pulse alongside pixel (0,0)
//   locked       timing lock status
//   timing_err   one-cycle pulse on a violation seen in CHECK or LOCK
//   h_total      last measured clocks per line (stats)
//   v_total      last measured lines per frame (stats)
//   err_count    saturating violation counter (stats)
//   dbg_state    lock FSM state (0 SEARCH, 1 CHECK, 2 LOCK)
//
// The pixel stream has no backpressure: pix_valid is a strobe that
// qualifies pix_x/pix_y/pix_rgb/frame_start for exactly one cycle; a
// consumer must take the pixel in that cycle. pix_* hold otherwise.
module vga_rx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_FP        = 16,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_FP        = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] H_LAST_CNT = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] V_LAST_CNT = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCK = 2'd2} state_t;

  // Stage 1 input registers plus one extra tap for edge detection
  logic        hs_q, vs_q, hs_d, vs_d;
  logic [11:0] rgb_q;

  logic [9:0]  hcnt, vcnt;
  logic        vs_pend;
  logic        seen_hs;    // first HS edge after reset has no previous line
  logic        frame_bad;  // some line of the current frame was bad

  state_t      state;
  logic [3:0]  good;

  logic        hs_fall, vs_fall, vs_take, boundary;
  logic [9:0]  hcnt_cur, vcnt_cur;
  logic        line_bad, frame_len_bad, sat_now, viol;
  logic        frame_ok, window, lock_next, err_next, pix_hit;
  logic [3:0]  good_inc;

  // hcnt_cur/vcnt_cur are the coordinates of the pixel currently in stage 1;
  // the registered hcnt/vcnt hold those of the previous pixel, which is what
  // the length checks need at a sync edge.
  always_comb begin
    hs_fall  = hs_d & ~hs_q;
    vs_fall  = vs_d & ~vs_q;
    vs_take  = vs_pend | vs_fall;   // simultaneous HS/VS edge consumes VS now
    boundary = hs_fall & vs_take;

    hcnt_cur = hs_fall ? 10'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1);
    vcnt_cur = vcnt;
    if (hs_fall)
      vcnt_cur = vs_take ? 10'd0 : ((vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1);

    line_bad      = hs_fall & seen_hs & (hcnt != H_LAST_CNT);
    frame_len_bad = boundary & (vcnt != V_LAST_CNT);
    // Flag saturation only on entry so a stuck sync gives a single event
    sat_now       = ((hcnt_cur == CNT_MAX) & (hcnt != CNT_MAX)) |
                    ((vcnt_cur == CNT_MAX) & (vcnt != CNT_MAX));
    viol          = line_bad | frame_len_bad | sat_now;
    frame_ok      = ~frame_bad & ~viol;

    window   = (hcnt_cur >= H_START) & (hcnt_cur <= H_END) &
               (vcnt_cur >= V_START) & (vcnt_cur <= V_END);
    good_inc = good + 4'd1;

    // Next lock state is used for pix_valid too, so locked, timing_err and
    // the pixel stream change in the same cycle.
    lock_next = ((state == LOCK) & ~viol) |
                ((state == CHECK) & boundary & frame_ok & (good_inc == LOCK_N));
    err_next  = viol & (state != SEARCH);
    pix_hit   = lock_next & window;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      rgb_q     <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      vs_pend   <= 1'b0;
      seen_hs   <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      hs_q      <= vga_hs;
      vs_q      <= vga_vs;
      hs_d      <= hs_q;
      vs_d      <= vs_q;
      rgb_q     <= {vga_r, vga_g, vga_b};
      hcnt      <= hcnt_cur;
      vcnt      <= vcnt_cur;
      seen_hs   <= seen_hs | hs_fall;
      if (hs_fall)
        vs_pend <= 1'b0;
      else if (vs_fall)
        vs_pend <= 1'b1;
      // The line check at a boundary belongs to the frame just ending and is
      // already folded into frame_ok, so the accumulator restarts clean.
      frame_bad <= boundary ? 1'b0 : (frame_bad | line_bad | sat_now);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      good       <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      locked     <= lock_next;
      timing_err <= err_next;
      case (state)
        SEARCH: if (boundary) begin
          state <= CHECK;
          good  <= '0;
        end
        CHECK: if (boundary) begin
          if (lock_next) state <= LOCK;
          good <= frame_ok ? good_inc : 4'd0;
        end
        LOCK: if (viol) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= pix_hit;
      frame_start <= pix_hit & (hcnt_cur == H_START) & (vcnt_cur == V_START);
      if (pix_hit) begin
        pix_x   <= hcnt_cur - H_START;
        pix_y   <= vcnt_cur - V_START;
        pix_rgb <= rgb_q;
      end
    end
  end

`ifdef VGA_RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_total   <= '0;
      v_total   <= '0;
      err_count <= '0;
    end else begin
      if (hs_fall & seen_hs)
        h_total <= hcnt + 10'd1;
      // Frame length is only a real check once SEARCH has seen a boundary
      if (boundary & (state != SEARCH))
        v_total <= vcnt + 10'd1;
      if (err_next & (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`else
  assign h_total   = '0;
  assign v_total   = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
`timescale 1ns/1ps
module tb_vga_rx;

  // Full horizontal timing, shortened vertical timing (5 lines/frame) so a
  // long multi-frame run stays small.
  localparam int H_TOT   = 800;
  localparam int H_START = 144;
  localparam int H_END   = 783;
  localparam int V_START = 2;
  localparam int V_END   = 3;
  localparam int V_TOT   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [9:0]  pix_x, pix_y, h_total, v_total;
  logic [11:0] pix_rgb;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  vga_rx #(
    .V_SYNC   (1),
    .V_BP     (1),
    .V_ACTIVE (2),
    .V_FP     (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err),
    .h_total     (h_total),
    .v_total     (v_total),
    .err_count   (err_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- generator position, delayed to DUT output alignment ----
  int gen_h = -1, gen_line = -1;
  int g1_h = -1, g1_line = -1, g2_h = -1, g2_line = -1;

  always @(posedge clk) begin
    g1_h    <= gen_h;
    g1_line <= gen_line;
    g2_h    <= g1_h;
    g2_line <= g1_line;
  end

  function automatic bit in_win(input int h, input int l);
    return (h >= H_START) && (h <= H_END) && (l >= V_START) && (l <= V_END);
  endfunction

  // ---------------- stream monitor ----------------
  int row_errs, row_valid, stream_bad;
  int rise_h = -9, rise_line = -9;
  bit fv_pending = 0;
  bit locked_prev = 0;
  int fv_x = -1, fv_y = -1, fv_rgb = -1, fv_fs = -1;

  always @(negedge clk) begin
    bit exp_fs;
    if (timing_err) row_errs++;
    if (pix_valid) begin
      row_valid++;
      if (!locked) stream_bad++;
      if (!in_win(g2_h, g2_line) || pix_x !== 10'(g2_h - H_START) ||
          pix_y !== 10'(g2_line - V_START) || pix_rgb !== 12'(g2_h))
        stream_bad++;
    end else if (locked && in_win(g2_h, g2_line)) begin
      stream_bad++;
    end
    exp_fs = pix_valid && g2_h == H_START && g2_line == V_START;
    if (frame_start !== exp_fs) stream_bad++;
    if (locked && !locked_prev) begin
      rise_h     = g2_h;
      rise_line  = g2_line;
      fv_pending = 1;
    end
    if (fv_pending && pix_valid) begin
      fv_x = pix_x; fv_y = pix_y; fv_rgb = pix_rgb; fv_fs = frame_start;
      fv_pending = 0;
    end
    locked_prev = locked;
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    check({tag, "_pix_rgb"}, pix_rgb, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_timing_err"}, timing_err, 0);
    check({tag, "_stats"}, {h_total, v_total, err_count}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vga_hs = 1'b1; vga_vs = 1'b1;
      {vga_r, vga_g, vga_b} = 12'h000;
      gen_h = -1; gen_line = -1;
      @(posedge clk); #1;
    end
  endtask

  // One frame of nlines lines; short_line (if >=0) is 799 clocks long.
  // rst_line (if >=0) pulses reset at pixel (300, rst_line-V_START).
  task automatic send_frame(input int nlines, input int short_line, input int rst_line);
    int len;
    logic [11:0] rgb;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_line) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        vga_hs = (h < 96) ? 1'b0 : 1'b1;
        vga_vs = (ln < 1) ? 1'b0 : 1'b1;
        rgb = 12'(h);
        {vga_r, vga_g, vga_b} = rgb;
        gen_h = h; gen_line = ln;
        if (ln == rst_line && h == H_START + 300) begin
          check("pre_reset_locked", locked, 1);
          check("pre_reset_valid", pix_valid, 1);
          #2 reset = 1'b0;
          #1 check_all_zero("midframe_reset");
        end
        if (ln == rst_line && h == H_START + 303) reset = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int kind;        // 0 frame, 1 idle gap with HS/VS high
    int nlines;
    int short_line;
    int gap;
    int rst_line;
    int exp_locked;
    int exp_errs;
    int exp_valid;   // -1: not compared
    int exp_state;
    int exp_h;
    int exp_v;
    int exp_ec;
    int chk_first;
  } row_t;

  localparam int NROWS = 17;
  row_t rows[NROWS];

  function automatic row_t mk(int kind, int nl, int sl, int gap, int rl, int lk,
                              int er, int va, int st, int eh, int ev, int ec, int cf);
    row_t r;
    r.kind = kind; r.nlines = nl; r.short_line = sl; r.gap = gap; r.rst_line = rl;
    r.exp_locked = lk; r.exp_errs = er; r.exp_valid = va; r.exp_state = st;
    r.exp_h = eh; r.exp_v = ev; r.exp_ec = ec; r.chk_first = cf;
    return r;
  endfunction

  initial begin
    int exp_h, exp_v, exp_ec;

    //               kind lines short gap  rst lock errs valid st  h    v  ec first
    rows[0]  = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 0, 0, 0); // SEARCH->CHECK
    rows[1]  = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 0, 0); // good=1
    rows[2]  = mk(0, 5,   -1, 0,    -1,  1,   0,   1280, 2, 800, 5, 0, 1); // lock
    rows[3]  = mk(0, 5,   2,  0,    -1,  0,   1,   640,  0, 800, 5, 1, 0); // 799-clock line
    rows[4]  = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 1, 0);
    rows[5]  = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 1, 0);
    rows[6]  = mk(0, 5,   -1, 0,    -1,  1,   0,   1280, 2, 800, 5, 1, 0); // relock
    rows[7]  = mk(1, 0,   -1, 1100, -1,  0,   1,   0,    0, 800, 5, 2, 0); // hcnt saturates
    rows[8]  = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 2, 0);
    rows[9]  = mk(0, 4,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 2, 0); // short frame, good=1
    rows[10] = mk(0, 5,   -1, 0,    -1,  0,   1,   0,    1, 800, 4, 3, 0); // bad frame seen
    rows[11] = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 3, 0);
    rows[12] = mk(0, 5,   -1, 0,    -1,  1,   0,   1280, 2, 800, 5, 3, 0);
    rows[13] = mk(0, 5,   -1, 0,    3,   0,   0,   -1,   0, 0,   0, 0, 0); // reset mid-frame
    rows[14] = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 0, 0, 0);
    rows[15] = mk(0, 5,   -1, 0,    -1,  0,   0,   0,    1, 800, 5, 0, 0);
    rows[16] = mk(0, 5,   -1, 0,    -1,  1,   0,   1280, 2, 800, 5, 0, 0);

    // ---------------- reset ----------------
    reset = 1'b0;
    vga_hs = 1'b1; vga_vs = 1'b1;
    {vga_r, vga_g, vga_b} = 12'h000;
    repeat (5) @(posedge clk);
    #1 check_all_zero("reset_state");
    reset = 1'b1;
    idle(3);

    for (int i = 0; i < NROWS; i++) begin
      row_errs = 0; row_valid = 0; stream_bad = 0;
      if (rows[i].kind == 0)
        send_frame(rows[i].nlines, rows[i].short_line, rows[i].rst_line);
      else
        idle(rows[i].gap);

      check($sformatf("row%0d_locked", i), locked, rows[i].exp_locked);
      check($sformatf("row%0d_err_pulses", i), row_errs, rows[i].exp_errs);
      check($sformatf("row%0d_state", i), dbg_state, rows[i].exp_state);
      check($sformatf("row%0d_stream_errors", i), stream_bad, 0);
      if (rows[i].exp_valid >= 0)
        check($sformatf("row%0d_valid_count", i), row_valid, rows[i].exp_valid);
`ifdef VGA_RX_STATS_EN
      exp_h = rows[i].exp_h; exp_v = rows[i].exp_v; exp_ec = rows[i].exp_ec;
`else
      exp_h = 0; exp_v = 0; exp_ec = 0;
`endif
      check($sformatf("row%0d_h_total", i), h_total, exp_h);
      check($sformatf("row%0d_v_total", i), v_total, exp_v);
      check($sformatf("row%0d_err_count", i), err_count, exp_ec);

      if (rows[i].chk_first != 0) begin
        check("lock_rise_line", rise_line, 0);
        check("lock_rise_h", rise_h, 0);
        check("first_pix_x", fv_x, 0);
        check("first_pix_y", fv_y, 0);
        check("first_pix_rgb", fv_rgb, 'h090);
        check("first_frame_start", fv_fs, 1);
        check("hold_pix_valid", pix_valid, 0);
        check("hold_pix_x", pix_x, 639);
        check("hold_pix_y", pix_y, 1);
        check("hold_pix_rgb", pix_rgb, 783);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
